// File: rtl/ts_stub_sequencer_pkg.sv
// Shared constants, state type and credit helper for the track-stub read sequencer.
package ts_stub_sequencer_pkg;

    localparam int STUB_CNT_BITS  = 8;
    localparam int STUB_WORD_BITS = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    // A read may issue only if the buffer still has room once everything in flight lands.
    function automatic logic credit_ok(input logic [1:0] occ, input logic inflight, input logic pop);
        logic [2:0] sum;
        sum = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
        return (sum < 3'd2);
    endfunction

endpackage

// File: rtl/ts_stub_sequencer_cntr.sv
// Remaining-stub down-counter; deliberately without reset, only meaningful after a load.
module TS_stub_cntr
    import ts_stub_sequencer_pkg::*;
#(
    parameter int CNT_BITS = STUB_CNT_BITS
) (
    input  logic                clk,
    input  logic                ld_en,
    input  logic                cnt_en,
    input  logic [CNT_BITS-1:0] init,
    output logic                is_zero
);

    logic [CNT_BITS-1:0] cnt_q;
    logic [CNT_BITS-1:0] cnt_d;

    // Next count: load wins over decrement; never wraps below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (ld_en) begin
            cnt_d = init;
        end else if (cnt_en && (cnt_q != {CNT_BITS{1'b0}})) begin
            cnt_d = cnt_q - {{(CNT_BITS-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign is_zero = (cnt_q == {CNT_BITS{1'b0}});

endmodule

// File: rtl/ts_stub_sequencer.sv
// Per-crossing stub read sequencer: header in, one RAM read per cycle, 2-entry
// output buffer with valid/ready, and a one-cycle done pulse per crossing.
module ts_stub_sequencer
    import ts_stub_sequencer_pkg::*;
#(
    parameter int CNT_BITS  = STUB_CNT_BITS,
    parameter int ADDR_BITS = 8,
    parameter int BX_BITS   = 8,
    parameter int STUB_BITS = STUB_WORD_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hdr_valid,
    output logic                 hdr_ready,
    input  logic [CNT_BITS-1:0]  hdr_cnt,
    input  logic [ADDR_BITS-1:0] hdr_base,
    input  logic [BX_BITS-1:0]   hdr_bx,
    output logic                 mem_re,
    output logic [ADDR_BITS-1:0] mem_addr,
    input  logic [STUB_BITS-1:0] mem_data,
    output logic                 stub_valid,
    input  logic                 stub_ready,
    output logic [STUB_BITS-1:0] stub_data,
    output logic [BX_BITS-1:0]   stub_bx,
    output logic                 stub_last,
    output logic                 done
);

    seq_state_e           state_q, state_d;
    logic                 hdr_ready_q, hdr_ready_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [BX_BITS-1:0]   bx_q, bx_d;
    logic [1:0]           occ_q, occ_d;
    logic [STUB_BITS-1:0] head_q, head_d;
    logic [STUB_BITS-1:0] tail_q, tail_d;
    logic                 inflight_q, inflight_d;

    logic       accept_s;
    logic       rd_s;
    logic       pop_s;
    logic       is_zero_s;
    logic [1:0] occ_pop_s;

    TS_stub_cntr #(
        .CNT_BITS (CNT_BITS)
    ) u_cntr (
        .clk     (clk),
        .ld_en   (accept_s),
        .cnt_en  (rd_s),
        .init    (hdr_cnt),
        .is_zero (is_zero_s)
    );

    assign stub_valid = (occ_q != 2'd0);
    assign pop_s      = stub_valid & stub_ready;
    assign accept_s   = (state_q == ST_IDLE) & hdr_ready_q & hdr_valid;
    assign rd_s       = (state_q == ST_RUN) & ~is_zero_s & credit_ok(occ_q, inflight_q, pop_s);

    // Crossing FSM, read address and BX capture.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        bx_d       = bx_q;
        inflight_d = rd_s;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    addr_d  = hdr_base;
                    bx_d    = hdr_bx;
                    state_d = (hdr_cnt == {CNT_BITS{1'b0}}) ? ST_DONE : ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (rd_s) begin
                    addr_d = addr_q + {{(ADDR_BITS-1){1'b0}}, 1'b1};
                end else begin
                    addr_d = addr_q;
                end
                state_d = is_zero_s ? ST_DRAIN : ST_RUN;
            end
            ST_DRAIN: begin
                // The buffer counts as empty once this cycle's pop takes the final entry.
                if (!inflight_q && ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop_s))) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        hdr_ready_d = (state_d == ST_IDLE);
    end

    // Two-entry FIFO: pop shifts the tail forward, returned data lands behind what remains.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        occ_pop_s = occ_q;
        if (pop_s) begin
            head_d    = tail_q;
            occ_pop_s = occ_q - 2'd1;
        end else begin
            occ_pop_s = occ_q;
        end
        if (inflight_q) begin
            if (occ_pop_s == 2'd0) begin
                head_d = mem_data;
            end else begin
                tail_d = mem_data;
            end
            occ_d = occ_pop_s + 2'd1;
        end else begin
            occ_d = occ_pop_s;
        end
    end

    // State and datapath registers; reset abandons any crossing in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hdr_ready_q <= 1'b0;
            addr_q      <= {ADDR_BITS{1'b0}};
            bx_q        <= {BX_BITS{1'b0}};
            occ_q       <= 2'd0;
            head_q      <= {STUB_BITS{1'b0}};
            tail_q      <= {STUB_BITS{1'b0}};
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_ready_q <= hdr_ready_d;
            addr_q      <= addr_d;
            bx_q        <= bx_d;
            occ_q       <= occ_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            inflight_q  <= inflight_d;
        end
    end

    assign hdr_ready = hdr_ready_q;
    assign mem_re    = rd_s;
    assign mem_addr  = addr_q;
    assign stub_data = head_q;
    assign stub_bx   = bx_q;
    assign stub_last = stub_valid & (state_q == ST_DRAIN) & (occ_q == 2'd1) & ~inflight_q;
    assign done      = (state_q == ST_DONE);

endmodule
